dev_bridge: RTL and testbench
=============================

DEV_BRIDGE -- requirements
Module: dev_bridge

Interface
REQ-001 The block SHALL provide the following parameters:
  - TIMEOUT_CYC, default 16, ack-wait limit in cycles (range 2..255).
  - DEV_BASE, default 32'h0000_7F00, lowest device byte address.
  - DEV_LIMIT, default 32'h0000_7F1F, highest device byte address.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset.
REQ-003 The block SHALL have the following ports:
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous, active-low reset.
  - ALUout_M  in  32  MEM-stage byte address.
  - WD_M  in  32  MEM-stage store data.
  - MemRead_M  in  1  load in MEM.
  - MemWrite_M  in  1  store in MEM.
  - HitDM  out  1  device-range access in MEM; feeds the MEM/WB register.
  - DIN  out  32  device read data; feeds the MEM/WB register.
  - stall_M  out  1  freeze PC/IF/ID/EX/MEM registers.
  - dev_req  out  1  device bus request.
  - dev_we  out  1  device write strobe.
  - dev_addr  out  32  word-aligned device address.
  - dev_wdata  out  32  device write data.
  - dev_ack  in  1  device completion.
  - dev_rdata  in  32  device read data.
  - bus_err  out  1  timeout pulse.

Function
REQ-004 acc SHALL be defined as (MemRead_M|MemWrite_M) & (DEV_BASE<=ALUout_M<=DEV_LIMIT).
REQ-005 HitDM SHALL equal acc combinationally in every state.
REQ-006 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-007 In IDLE with acc=1, stall_M SHALL be 1 combinationally.
REQ-008 On the next edge from IDLE with acc=1, the FSM SHALL enter REQ, set dev_req=1, latch dev_addr={ALUout_M[31:2],2'b00} and dev_wdata=WD_M, and set dev_we=MemWrite_M.
REQ-009 In REQ, stall_M SHALL be 1 and dev_addr, dev_wdata and dev_we SHALL hold stable.
REQ-010 At an edge in REQ with dev_ack=1, the FSM SHALL register DIN=dev_rdata (or DIN=0 for a write), clear dev_req and dev_we, and enter DONE.
REQ-011 In DONE, stall_M SHALL be 0 so that the pipeline advances and the MEM/WB register captures DIN.
REQ-012 At the next edge, DONE SHALL unconditionally go to IDLE, so the same instruction never re-triggers.
REQ-013 Minimum device-access latency SHALL be 3 cycles with 2 stall cycles; each extra REQ cycle SHALL add one stall cycle.
REQ-014 DIN SHALL hold its value until the next capture.
REQ-015 dev_ack SHALL be ignored in IDLE and DONE.
REQ-016 MemRead_M=MemWrite_M=1 SHALL be treated as a write.
REQ-017 A non-device access SHALL never stall and SHALL never assert dev_req.
REQ-018 Back-to-back device accesses SHALL each run a full IDLE->REQ->DONE sequence.

Reset
REQ-019 reset=0 SHALL asynchronously force state=IDLE, dev_req=0, dev_we=0, dev_addr=0, dev_wdata=0, DIN=0, bus_err=0 and the timeout counter to 0.
REQ-020 After reset, stall_M SHALL follow REQ-007 combinationally.
REQ-021 A reset during REQ SHALL drop dev_req immediately, without waiting for the next edge, and the aborted access SHALL not be retried.
REQ-022 Release of reset SHALL take effect on the first clk edge with reset=1.

Configuration
REQ-023 With DEV_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REQ entry and increment each REQ cycle without dev_ack.
REQ-024 With DEV_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC-1 with dev_ack=0, the next edge SHALL enter DONE with DIN=0 and dev_req=0, and bus_err SHALL be 1 for that DONE cycle only.
REQ-025 With DEV_TIMEOUT_EN defined, dev_ack arriving on the same edge as timeout expiry SHALL win: normal capture, no bus_err.
REQ-026 Without DEV_TIMEOUT_EN, there SHALL be no counter, REQ SHALL wait indefinitely for dev_ack, and bus_err SHALL be tied to 0.

Verification
REQ-027 Scenario: load 0x7F04 with dev_ack one cycle after dev_req and dev_rdata=0x12345678 -> dev_addr=0x7F04, stall_M high for 2 cycles, DIN=0x12345678 in DONE, HitDM=1.
REQ-028 Scenario: store 0x7F10 with WD_M=0xA5A5A5A5 and dev_ack after 4 cycles -> dev_we=1 and dev_wdata=0xA5A5A5A5 stable throughout REQ, stall_M high for 5 cycles, DIN=0.
REQ-029 Scenario: load 0x1000 -> HitDM=0, stall_M=0, dev_req never asserted.
REQ-030 Scenario: two consecutive loads at 0x7F00 and 0x7F08 -> two distinct dev_req pulses, with DIN capturing each rdata in order.
REQ-031 Scenario: with DEV_TIMEOUT_EN and TIMEOUT_CYC=16, no dev_ack -> DONE after 16 REQ cycles, bus_err=1 for 1 cycle, DIN=0; repeat with dev_ack on the final cycle -> no bus_err.
REQ-032 Scenario: reset=0 asserted mid-REQ between edges -> dev_req falls immediately, and after release state=IDLE with all outputs at 0.

Source files
------------

// File: rtl/dev_bridge.sv
// MEM-stage bridge from the pipeline to a memory-mapped device bus. Device accesses stall the pipeline until dev_ack.
// Optional ack-wait timeout with bus_err pulse: define DEV_TIMEOUT_EN.
module dev_bridge #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] DEV_BASE    = 32'h0000_7F00,
  parameter logic [31:0] DEV_LIMIT   = 32'h0000_7F1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUout_M,
  input  logic [31:0] WD_M,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  output logic        HitDM,
  output logic [31:0] DIN,
  output logic        stall_M,
  output logic        dev_req,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata,
  output logic        bus_err
);

  // state | meaning
  // IDLE  | no device transfer; a device access stalls and launches REQ
  // REQ   | dev_req high, waiting for dev_ack (or timeout)
  // DONE  | DIN valid, pipeline advances; always returns to IDLE
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state_q, state_d;
  logic   acc;
  logic   expire;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("dev_bridge: TIMEOUT_CYC must be in 2..255");
  end

  assign acc     = (MemRead_M | MemWrite_M) && (ALUout_M >= DEV_BASE) && (ALUout_M <= DEV_LIMIT);
  assign HitDM   = acc;
  assign dev_req = (state_q == REQ);

  always_comb begin
    state_d = state_q;
    stall_M = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          stall_M = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_M = 1'b1;
        if (dev_ack || expire) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_we    <= 1'b0;
      DIN       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            dev_addr  <= {ALUout_M[31:2], 2'b00};
            dev_wdata <= WD_M;
            dev_we    <= MemWrite_M;
          end
        end
        REQ: begin
          // ack takes priority over an expiring timeout
          if (dev_ack) begin
            DIN    <= dev_we ? 32'h0 : dev_rdata;
            dev_we <= 1'b0;
          end else if (expire) begin
            DIN    <= 32'h0;
            dev_we <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DEV_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] to_cnt_q;

  assign expire = (state_q == REQ) && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else if (state_q == IDLE && acc) begin
      to_cnt_q <= '0;
    end else if (state_q == REQ && !dev_ack && !expire) begin
      to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_err <= 1'b0;
    else        bus_err <= expire && !dev_ack;
  end
`else
  assign expire  = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_dev_bridge.sv
// Self-checking bench for dev_bridge: directed scenarios plus randomized pipeline traffic
// compared every cycle against a transaction-level model.
module tb_dev_bridge;

  localparam logic [31:0] BASE  = 32'h0000_7F00;
  localparam logic [31:0] LIMIT = 32'h0000_7F1F;
  localparam int          TO    = 16;
`ifdef DEV_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUout_M, WD_M, dev_rdata;
  logic        MemRead_M, MemWrite_M, dev_ack;
  logic        HitDM, stall_M, dev_req, dev_we, bus_err;
  logic [31:0] DIN, dev_addr, dev_wdata;

  dev_bridge dut (
    .clk(clk), .reset(reset), .ALUout_M(ALUout_M), .WD_M(WD_M),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .HitDM(HitDM), .DIN(DIN),
    .stall_M(stall_M), .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction-level model: one outstanding bus transfer, then one completion cycle.
  bit          m_out, m_fin, m_we, m_err, m_adv;
  int          m_wait;
  logic [31:0] m_addr, m_wdata, m_din;

  function automatic bit acc_now();
    return (MemRead_M | MemWrite_M) && (ALUout_M >= BASE) && (ALUout_M <= LIMIT);
  endfunction

  function automatic bit stall_now();
    return m_out || (!m_fin && acc_now());
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_out <= 0; m_fin <= 0; m_we <= 0; m_err <= 0; m_adv <= 1; m_wait <= 0;
      m_addr <= '0; m_wdata <= '0; m_din <= '0;
    end else begin
      m_adv <= !stall_now();
      if (m_out) begin
        if (dev_ack) begin
          m_din <= m_we ? 32'h0 : dev_rdata;
          m_out <= 0; m_fin <= 1; m_we <= 0;
        end else if (TO_EN && m_wait == TO - 1) begin
          m_din <= 32'h0;
          m_out <= 0; m_fin <= 1; m_we <= 0; m_err <= 1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_fin) begin
        m_fin <= 0; m_err <= 0;
      end else if (acc_now()) begin
        m_out   <= 1;
        m_wait  <= 0;
        m_addr  <= {ALUout_M[31:2], 2'b00};
        m_wdata <= WD_M;
        m_we    <= MemWrite_M;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_HitDM",     {31'b0, HitDM},   {31'b0, acc_now()});
      chk("cyc_stall_M",   {31'b0, stall_M}, {31'b0, stall_now()});
      chk("cyc_dev_req",   {31'b0, dev_req}, {31'b0, m_out});
      chk("cyc_dev_we",    {31'b0, dev_we},  {31'b0, m_we});
      chk("cyc_dev_addr",  dev_addr,  m_addr);
      chk("cyc_dev_wdata", dev_wdata, m_wdata);
      chk("cyc_DIN",       DIN,       m_din);
      chk("cyc_bus_err",   {31'b0, bus_err}, {31'b0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic ack, input logic [31:0] rdat);
    ALUout_M = a; MemRead_M = rd; MemWrite_M = wr; WD_M = wd; dev_ack = ack; dev_rdata = rdat;
  endtask

  int stall_cnt, pulses;
  bit prev_req;

  task automatic rand_instr();
    int kind, op;
    logic [31:0] bnd [6];
    bnd[0] = 32'h7EFF; bnd[1] = 32'h7F00; bnd[2] = 32'h7F1F;
    bnd[3] = 32'h7F20; bnd[4] = 32'h7EFC; bnd[5] = 32'h7F1C;
    kind = $urandom_range(0, 9);
    if (kind < 4)      ALUout_M = BASE + 32'($urandom_range(0, 31));
    else if (kind < 7) ALUout_M = bnd[$urandom_range(0, 5)];
    else               ALUout_M = $urandom;
    op = $urandom_range(0, 3);
    MemRead_M  = op[0];
    MemWrite_M = op[1];
    WD_M       = $urandom;
  endtask

  initial begin
    set_in(32'h0, 0, 0, 32'h0, 0, 32'h0);
    reset = 1'b0;
    repeat (2) step();
    chk("rst_dev_req", {31'b0, dev_req}, 32'h0);
    chk("rst_DIN", DIN, 32'h0);
    chk("rst_dev_addr", dev_addr, 32'h0);
    chk("rst_stall_M", {31'b0, stall_M}, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
    reset = 1'b1;
    chk_en = 1'b1;
    step();

    // load 0x7F04, ack in first REQ cycle
    stall_cnt = 0;
    set_in(32'h7F04, 1, 0, 32'h0, 0, 32'h0); #1;
    chk("ld_HitDM", {31'b0, HitDM}, 32'h1);
    stall_cnt += int'(stall_M);
    step(); dev_ack = 1; dev_rdata = 32'h1234_5678; #1;
    chk("ld_dev_addr", dev_addr, 32'h7F04);
    chk("ld_dev_req", {31'b0, dev_req}, 32'h1);
    stall_cnt += int'(stall_M);
    step(); dev_ack = 0; #1;
    chk("ld_DIN", DIN, 32'h1234_5678);
    chk("ld_done_stall", {31'b0, stall_M}, 32'h0);
    stall_cnt += int'(stall_M);
    chk("ld_stall_cycles", stall_cnt, 2);
    step(); set_in(32'h0, 0, 0, 32'h0, 0, 32'h0);

    // store 0x7F10, ack in fourth REQ cycle, WD_M scrambled after launch
    stall_cnt = 0;
    set_in(32'h7F10, 0, 1, 32'hA5A5_A5A5, 0, 32'hDEAD_BEEF); #1;
    stall_cnt += int'(stall_M);
    for (int i = 0; i < 4; i++) begin
      step(); dev_ack = (i == 3); WD_M = $urandom; #1;
      chk("st_dev_we", {31'b0, dev_we}, 32'h1);
      chk("st_dev_wdata", dev_wdata, 32'hA5A5_A5A5);
      stall_cnt += int'(stall_M);
    end
    step(); dev_ack = 0; #1;
    chk("st_DIN", DIN, 32'h0);
    chk("st_done_we", {31'b0, dev_we}, 32'h0);
    chk("st_stall_cycles", stall_cnt, 5);

    // non-device load
    step(); set_in(32'h1000, 1, 0, 32'h0, 1, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nd_HitDM", {31'b0, HitDM}, 32'h0);
      chk("nd_stall", {31'b0, stall_M}, 32'h0);
      chk("nd_req", {31'b0, dev_req}, 32'h0);
      step();
    end

    // back-to-back loads at 0x7F00 and 0x7F08
    pulses = 0; prev_req = 0;
    set_in(32'h7F00, 1, 0, 32'h0, 0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (dev_req && !prev_req) pulses++;
      prev_req = dev_req;
      if (c == 2) chk("b2b_DIN0", DIN, 32'h1111_1111);
      if (c == 5) chk("b2b_DIN1", DIN, 32'h2222_2222);
      step();
      dev_ack = 0;
      if (c == 0) begin dev_ack = 1; dev_rdata = 32'h1111_1111; end
      if (c == 2) ALUout_M = 32'h7F08;
      if (c == 3) begin dev_ack = 1; dev_rdata = 32'h2222_2222; end
    end
    chk("b2b_req_pulses", pulses, 2);
    set_in(32'h0, 0, 0, 32'h0, 0, 32'h0);

    // read and write together behave as a write
    step(); set_in(32'h7F18, 1, 1, 32'h0BAD_CAFE, 0, 32'h0);
    step(); dev_ack = 1; dev_rdata = 32'hFFFF_0000; #1;
    chk("rw_dev_we", {31'b0, dev_we}, 32'h1);
    step(); dev_ack = 0; #1;
    chk("rw_DIN", DIN, 32'h0);
    step(); set_in(32'h0, 0, 0, 32'h0, 0, 32'h0);

`ifdef DEV_TIMEOUT_EN
    for (int rep = 0; rep < 2; rep++) begin
      step(); set_in(32'h7F0C, 1, 0, 32'h0, 0, 32'h0);
      for (int i = 0; i < TO; i++) begin
        step(); dev_ack = (rep == 1 && i == TO - 1); dev_rdata = 32'hCAFE_F00D; #1;
        chk("to_req_held", {31'b0, dev_req}, 32'h1);
      end
      step(); dev_ack = 0; #1;
      chk("to_done_req", {31'b0, dev_req}, 32'h0);
      chk("to_bus_err", {31'b0, bus_err}, (rep == 0) ? 32'h1 : 32'h0);
      chk("to_DIN", DIN, (rep == 0) ? 32'h0 : 32'hCAFE_F00D);
      step(); #1;
      chk("to_err_clear", {31'b0, bus_err}, 32'h0);
      set_in(32'h0, 0, 0, 32'h0, 0, 32'h0);
    end
`endif

    // reset asserted between edges while in REQ
    step(); set_in(32'h7F14, 1, 0, 32'h1234_0000, 0, 32'h0);
    step(); #1;
    chk("rr_req_before", {31'b0, dev_req}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rr_req_drop", {31'b0, dev_req}, 32'h0);
    chk("rr_addr_clr", dev_addr, 32'h0);
    chk("rr_stall_idle_acc", {31'b0, stall_M}, 32'h1);
    set_in(32'h0, 0, 0, 32'h0, 0, 32'h0); #1;
    chk("rr_stall_clear", {31'b0, stall_M}, 32'h0);
    step(); step();
    reset = 1'b1;
    step(); #1;
    chk("rr_post_req", {31'b0, dev_req}, 32'h0);
    chk("rr_post_we", {31'b0, dev_we}, 32'h0);
    chk("rr_post_DIN", DIN, 32'h0);
    chk("rr_post_wdata", dev_wdata, 32'h0);

    // randomized pipeline traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      if (m_adv) rand_instr();
      dev_ack   = ($urandom_range(0, 9) < 4);
      dev_rdata = $urandom;
    end
    set_in(32'h0, 0, 0, 32'h0, 1, 32'h0);
    for (int c = 0; c < 40 && (m_out || m_fin); c++) step();
    dev_ack = 0;
    step(); step();
    chk("end_idle", {31'b0, dev_req}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
